// File: rtl/lfsr_seq_ctrl_if.sv
// Signal bundle between the LFSR sequencer (slave) and its environment (master):
// start request, LFSR control/result lines and the downstream valid/ready result port.
interface lfsr_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_init;
    logic             lfsr_shift;
    logic [WIDTH-1:0] lfsr_result;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output start, seed, count, lfsr_result, out_ready,
        input  busy, lfsr_load, lfsr_init, lfsr_shift, out_data, out_valid
    );

    modport slave (
        input  start, seed, count, lfsr_result, out_ready,
        output busy, lfsr_load, lfsr_init, lfsr_shift, out_data, out_valid
    );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the 8-bit LFSR stage: load seed, issue `count` shifts, capture and hand off.
// Optional LFSR_SEQ_CTRL_ABORT_EN adds an abort input that cancels LOAD/SHIFT/CAPT.
module lfsr_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef LFSR_SEQ_CTRL_ABORT_EN
    input  logic abort,
`endif
    lfsr_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CAPT  = 3'd3,
        VALID = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] init_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             abort_hit;

`ifdef LFSR_SEQ_CTRL_ABORT_EN
    assign abort_hit = abort && ((state == LOAD) || (state == SHIFT) || (state == CAPT));
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides every transition out of the working states.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    state_next = (remaining != '0) ? SHIFT : CAPT;
            SHIFT:   if (remaining == CNT_W'(1)) state_next = CAPT;
            CAPT:    state_next = VALID;
            VALID:   if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q    <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        init_q    <= bus.seed;
                        remaining <= bus.count;
                    end
                end
                SHIFT: begin
                    remaining <= remaining - CNT_W'(1);
                end
                CAPT: begin
                    if (!abort_hit) begin
                        data_q  <= bus.lfsr_result;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.lfsr_load  = (state == LOAD);
    assign bus.lfsr_shift = (state == SHIFT);
    assign bus.lfsr_init  = init_q;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl with a behavioural 8-bit Galois LFSR (taps 0xC2).
// Define LFSR_SEQ_CTRL_ABORT_EN to also exercise the abort path.
module tb_lfsr_seq_ctrl;

    typedef struct {
        logic [7:0] data;
        int         latency;
        int         shifts;
        int         startEdge;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] lfsrReg;
    int         cycleNum;
    int         nChecks;
    int         nFails;
    int         shiftCnt;
    logic       prevValid;
    logic [7:0] heldData;
    exp_t       expQ[$];

    lfsr_seq_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

`ifdef LFSR_SEQ_CTRL_ABORT_EN
    logic abort;
    lfsr_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .abort(abort), .bus(bus));
`else
    lfsr_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleNum = 0;
    always @(posedge clk) cycleNum++;

    // Stand-in for the downstream LFSR stage; it is deliberately not reset.
    initial lfsrReg = 8'h00;
    always @(posedge clk) begin
        if (bus.lfsr_load)
            lfsrReg <= bus.lfsr_init;
        else if (bus.lfsr_shift)
            lfsrReg <= {lfsrReg[6:0], 1'b0} ^ (lfsrReg[7] ? 8'hC2 : 8'h00);
    end
    assign bus.lfsr_result = lfsrReg;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycleNum);
        end
    endtask

    task automatic issueStart(input logic [7:0] s, input logic [7:0] c);
        @(negedge clk);
        bus.seed  = s;
        bus.count = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] c, input logic [7:0] expData);
        exp_t e;
        @(negedge clk);
        e.data      = expData;
        e.latency   = int'(c) + 2;
        e.shifts    = int'(c);
        e.startEdge = cycleNum + 1;
        expQ.push_back(e);
        bus.seed  = s;
        bus.count = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.out_valid) return;
        end
        nChecks++;
        nFails++;
        $display("[TB] FAIL waitIdle: still busy=%0b after %0d cycles, required busy=0", bus.busy, limit);
    endtask

    // Monitor: pops one expectation per out_valid rise and checks data is held while valid.
    initial begin
        shiftCnt  = 0;
        prevValid = 1'b0;
        heldData  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                shiftCnt  = 0;
                prevValid = 1'b0;
            end else begin
                if (!bus.busy) shiftCnt = 0;
                if (bus.lfsr_shift) shiftCnt++;
                if (bus.out_valid && !prevValid) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpected_valid: got out_valid=1 data=0x%0h, required no output", bus.out_data);
                    end else begin
                        exp_t e;
                        e = expQ.pop_front();
                        checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
                        checkOutput("latency", 32'(cycleNum - e.startEdge), 32'(e.latency));
                        checkOutput("shift_cycles", 32'(shiftCnt), 32'(e.shifts));
                    end
                    heldData = bus.out_data;
                end else if (bus.out_valid) begin
                    checkOutput("held_data", 32'(bus.out_data), 32'(heldData));
                end
                prevValid = bus.out_valid;
            end
        end
    end

    initial begin
        nChecks       = 0;
        nFails        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.seed      = 8'h00;
        bus.count     = 8'h00;
        bus.out_ready = 1'b1;
`ifdef LFSR_SEQ_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_load", 32'(bus.lfsr_load), 32'd0);
        checkOutput("rst_shift", 32'(bus.lfsr_shift), 32'd0);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_init", 32'(bus.lfsr_init), 32'd0);
        rst = 1'b0;

        // Hand-computed vectors: seed, count, expected captured value.
        applyStimulus(8'h01, 8'd1, 8'h02); waitIdle(50);
        applyStimulus(8'h80, 8'd1, 8'hC2); waitIdle(50);
        applyStimulus(8'hA5, 8'd0, 8'hA5); waitIdle(50);
        applyStimulus(8'h01, 8'd8, 8'hC2); waitIdle(50);
        applyStimulus(8'hC2, 8'd1, 8'h46); waitIdle(50);

        // Backpressure with a start pulse that must be ignored while busy.
        bus.out_ready = 1'b0;
        applyStimulus(8'h01, 8'd3, 8'h08);
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        checkOutput("bp_valid_up", 32'(bus.out_valid), 32'd1);
        issueStart(8'hFF, 8'd7);
        repeat (3) @(negedge clk);
        checkOutput("bp_valid_hold", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_idle_after", 32'(bus.busy), 32'd0);
        checkOutput("bp_valid_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_data_kept", 32'(bus.out_data), 32'h08);
        checkOutput("bp_init_kept", 32'(bus.lfsr_init), 32'h01);

        // Asynchronous reset in the middle of a long shift run.
        issueStart(8'h01, 8'd200);
        repeat (20) @(negedge clk);
        checkOutput("pre_rst_shift", 32'(bus.lfsr_shift), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_shift", 32'(bus.lfsr_shift), 32'd0);
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h01, 8'd2, 8'h04); waitIdle(50);

`ifdef LFSR_SEQ_CTRL_ABORT_EN
        issueStart(8'h01, 8'd10);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle", 32'(bus.busy), 32'd0);
        checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_data", 32'(bus.out_data), 32'h04);
        repeat (5) @(negedge clk);
        checkOutput("abort_still_idle", 32'(bus.busy), 32'd0);
`endif

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Sequencer that sits directly upstream of the 8-bit LFSR stage and drives its init/load/shift controls. It accepts a start request carrying a seed and a shift count, loads the seed, and issues exactly `count` shift pulses. It then captures the LFSR result and presents it to the downstream consumer over a valid/ready handshake.

Parameters:
- WIDTH, 8: LFSR data width; seed, lfsr_init, lfsr_result and out_data widths.
- CNT_W, 8: width of the shift-count input and the internal remaining-shift counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- seed  input  WIDTH  initial LFSR value; latched with start.
- count  input  CNT_W  number of shifts; latched with start.
- busy  output  1  high in every state except IDLE.
- lfsr_load  output  1  drives the LFSR's synchronous load (its rst pin).
- lfsr_init  output  WIDTH  latched seed; drives the LFSR init.
- lfsr_shift  output  1  drives the LFSR shift enable.
- lfsr_result  input  WIDTH  current LFSR register value.
- out_data  output  WIDTH  captured final LFSR value.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - busy, lfsr_load, lfsr_shift and out_valid = 0.
  - out_data, lfsr_init and the counter = 0.
- States: IDLE, LOAD, SHIFT, CAPT, VALID. State outputs are decoded from registered state:
  - lfsr_load = (state == LOAD).
  - lfsr_shift = (state == SHIFT).
  - busy = (state != IDLE).
- IDLE: when start = 1, latch seed into lfsr_init and count into remaining, then go to LOAD. When start = 0, stay.
- LOAD: lasts one cycle; the LFSR loads lfsr_init on the closing edge.
  - Next state is SHIFT if remaining != 0, else CAPT.
- SHIFT: one shift per cycle.
  - remaining decrements every cycle.
  - When remaining == 1, go to CAPT.
  - The SHIFT state lasts exactly `count` cycles.
- CAPT: out_data <= lfsr_result and out_valid <= 1, then go to VALID.
- VALID: out_valid and out_data are held stable until out_ready = 1.
  - On the handshake edge, out_valid <= 0 and state goes to IDLE.
  - out_data keeps its last value after the handshake.
- Latency: out_valid is first high after count + 2 rising edges following the edge that sampled start. count = 0 gives 2 edges, and out_data = seed.
- count = 2^CNT_W - 1 (255) is legal and produces 255 shifts. There is no wrap of remaining.
- start while busy is ignored, and seed/count are not re-latched. A new start is accepted only once the state is back in IDLE, i.e. the cycle after the handshake.
- out_ready is ignored outside VALID.
- lfsr_init stays stable from LOAD until the next accepted start.
- Reset mid-operation: immediate return to IDLE.
  - Any pending out_valid is dropped.
  - lfsr_shift and lfsr_load deassert asynchronously.
  - The LFSR contents are not restored; the next start reloads them.

Optional Feature:
- Macro: LFSR_SEQ_CTRL_ABORT_EN.
- Defined: adds input port `abort` (1 bit).
  - abort = 1 in LOAD, SHIFT or CAPT returns the block to IDLE on the next edge.
  - No capture happens, out_valid stays 0 and out_data is unchanged.
  - abort in VALID or IDLE is ignored.
  - abort takes priority over every other transition in LOAD, SHIFT and CAPT.
- Undefined: no abort port; a sequence always runs to VALID.

Test Plan:
- seed=0x01, count=1, out_ready=1 → out_valid high 3 edges after start; out_data=0x02; exactly one lfsr_shift cycle.
- seed=0x80, count=1 → out_data=0xC2 (feedback taps at bits 1, 6 and 7 all set).
- seed=0xA5, count=0 → no lfsr_shift pulses; out_valid after 2 edges; out_data=0xA5.
- seed=0x01, count=3, out_ready held 0 for 5 cycles → out_data=0x08 held stable with out_valid=1 throughout; a start pulsed during the wait is ignored; IDLE follows the handshake.
- rst asserted mid-SHIFT (seed=0x01, count=200) → busy, lfsr_shift and out_valid drop to 0 immediately; a following start with seed=0x01, count=2 yields out_data=0x04.
- With LFSR_SEQ_CTRL_ABORT_EN: abort during SHIFT → IDLE next edge, out_valid never rises, out_data keeps its previous value.
